mux_sequencer: RTL and testbench



---
 rtl/spirose_mux_pkg.sv | 24 ++
 rtl/rising_edge_det.sv | 26 ++
 rtl/mux_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mux_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spirose_mux_pkg.sv
// Shared types and helpers for the column-multiplexing sequencer.
// Helpers return a fixed maximum width; callers size-cast to NB_MUX.
package spirose_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON
  } mux_state_t;

  localparam int unsigned MaxMux = 64;
  localparam logic [MaxMux-1:0] OneBit = MaxMux'(1);

  // Indices outside the line count yield an all-off pattern.
  function automatic logic [MaxMux-1:0] onehot(input int unsigned idx, input int unsigned nb_mux);
    return (idx < nb_mux) ? (OneBit << idx) : '0;
  endfunction

  // Pin level of an inactive line, as an XOR mask applied at the output register.
  function automatic logic [MaxMux-1:0] off_level(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/rising_edge_det.sv
// Registered 1-bit rising-edge detector; the edge is reported in the same cycle the input rises.
module rising_edge_det (
  input  logic clock_66,
  input  logic nrst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/mux_sequencer.sv
// Column-multiplexing controller: one-hot auto sequencing with dead time, or manual pass-through.
// All outputs come straight from flops; pin polarity is folded into the output register.
module mux_sequencer #(
  parameter int unsigned NB_MUX     = 8,
  parameter int unsigned DEAD_TIME  = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                      clock_66,
  input  logic                      nrst,
  input  logic                      enable,
  input  logic                      mode_auto,
  input  logic [NB_MUX-1:0]         manual_sel,
  input  logic                      column_ready,
  input  logic                      position_sync,
  output logic [NB_MUX-1:0]         mux_out,
  output logic [$clog2(NB_MUX)-1:0] mux_index,
  output logic                      turn_done,
  output logic                      overrun
);
  import spirose_mux_pkg::*;

  localparam int unsigned IdxW     = $clog2(NB_MUX);
  localparam int unsigned DeadLast = (DEAD_TIME > 0) ? DEAD_TIME - 1 : 0;
  localparam int unsigned CntW     = (DeadLast > 0) ? $clog2(DeadLast + 1) : 1;

  localparam logic [IdxW-1:0]   IdxLast = IdxW'(NB_MUX - 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(DeadLast);
  localparam logic [NB_MUX-1:0] OffMask = NB_MUX'(off_level(ACTIVE_LOW));

  mux_state_t        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [NB_MUX-1:0] mux_out_q, mux_out_d;
  logic              turn_q, turn_d;
  logic              over_q, over_d;

  logic sync_rise;
  logic mode_rise;

  rising_edge_det u_sync_edge (
    .clock_66 (clock_66),
    .nrst     (nrst),
    .sig_i    (position_sync),
    .rise_o   (sync_rise)
  );

  rising_edge_det u_mode_edge (
    .clock_66 (clock_66),
    .nrst     (nrst),
    .sig_i    (mode_auto),
    .rise_o   (mode_rise)
  );

  logic [NB_MUX-1:0] lines;
  logic              drive_on;
  logic [IdxW-1:0]   on_idx;
  logic              launch;
  logic [IdxW-1:0]   launch_idx;
  logic              launch_wrap;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    turn_d      = 1'b0;
    over_d      = 1'b0;
    lines       = '0;
    drive_on    = 1'b0;
    on_idx      = idx_q;
    launch      = 1'b0;
    launch_idx  = '0;
    launch_wrap = 1'b0;

    if (!enable || !mode_auto || mode_rise) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      wrap_d  = 1'b0;
      if (enable && !mode_auto) begin
        lines = manual_sel;
      end
    end else if (sync_rise) begin
      // Sync realigns to channel 0 and swallows a coincident column_ready.
      launch = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          launch = column_ready;
        end
        DEAD: begin
          over_d = column_ready;
          if (cnt_q == CntLast) begin
            state_d  = ON;
            drive_on = 1'b1;
            turn_d   = wrap_q;
            wrap_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        ON: begin
          drive_on = 1'b1;
          if (column_ready) begin
            launch      = 1'b1;
            launch_wrap = (idx_q == IdxLast);
            launch_idx  = launch_wrap ? '0 : idx_q + IdxW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (launch) begin
      idx_d = launch_idx;
      cnt_d = '0;
      if (DEAD_TIME == 0) begin
        state_d  = ON;
        drive_on = 1'b1;
        on_idx   = launch_idx;
        turn_d   = launch_wrap;
        wrap_d   = 1'b0;
      end else begin
        state_d  = DEAD;
        drive_on = 1'b0;
        wrap_d   = launch_wrap;
      end
    end

    if (drive_on) begin
      lines = NB_MUX'(onehot(32'(on_idx), NB_MUX));
    end
    mux_out_d = lines ^ OffMask;
  end

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      mux_out_q <= OffMask;
      turn_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      mux_out_q <= mux_out_d;
      turn_q    <= turn_d;
      over_q    <= over_d;
    end
  end

  assign mux_out   = mux_out_q;
  assign mux_index = idx_q;
  assign turn_done = turn_q;
  assign overrun   = over_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Scoreboard bench for mux_sequencer: default 8-line instance and a 5-line active-low, no-gap one.
module tb_mux_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] out;
    logic [2:0] idx;
    logic       turn;
    logic       over;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   drain = 0;
  logic stim_done = 1'b0;

  logic       nrst8, en8, mode8, cr8, sync8;
  logic [7:0] sel8;
  logic [7:0] out8;
  logic [2:0] idx8;
  logic       td8, ov8;

  logic       nrst5, en5, mode5, cr5, sync5;
  logic [4:0] sel5;
  logic [4:0] out5;
  logic [2:0] idx5;
  logic       td5, ov5;

  logic [7:0] ch8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [4:0] val5 [6] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F, 5'h1E};
  logic [2:0] ix5 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  mux_sequencer u_dut8 (
    .clock_66      (clk),
    .nrst          (nrst8),
    .enable        (en8),
    .mode_auto     (mode8),
    .manual_sel    (sel8),
    .column_ready  (cr8),
    .position_sync (sync8),
    .mux_out       (out8),
    .mux_index     (idx8),
    .turn_done     (td8),
    .overrun       (ov8)
  );

  mux_sequencer #(
    .NB_MUX     (5),
    .DEAD_TIME  (0),
    .ACTIVE_LOW (1'b1)
  ) u_dut5 (
    .clock_66      (clk),
    .nrst          (nrst5),
    .enable        (en5),
    .mode_auto     (mode5),
    .manual_sel    (sel5),
    .column_ready  (cr5),
    .position_sync (sync5),
    .mux_out       (out5),
    .mux_index     (idx5),
    .turn_done     (td5),
    .overrun       (ov5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic p8(input int c0, input int c1, input logic [7:0] o, input logic [2:0] i,
                    input int turn_at = -1, input int over_at = -1);
    for (int c = c0; c <= c1; c++) begin
      q8.push_back('{cyc: c, out: o, idx: i, turn: (c == turn_at), over: (c == over_at)});
    end
  endtask

  task automatic p5(input int c0, input int c1, input logic [4:0] o, input logic [2:0] i,
                    input int turn_at = -1);
    for (int c = c0; c <= c1; c++) begin
      q5.push_back('{cyc: c, out: {3'b000, o}, idx: i, turn: (c == turn_at), over: 1'b0});
    end
  endtask

  task automatic run8();
    int t;
    p8(1, 9, 8'h00, 3'd0);
    at(3); nrst8 = 1'b1;
    // First pulse from IDLE: four-cycle gap, then channel 0.
    at(10); cr8 = 1'b1;
    p8(11, 14, 8'h00, 3'd0);
    p8(15, 29, 8'h01, 3'd0);
    at(11); cr8 = 1'b0;
    // Full turn: channels 1..7 then wrap to 0 with turn_done.
    for (int k = 1; k <= 8; k++) begin
      t = 10 + 20 * k;
      at(t); cr8 = 1'b1;
      p8(t + 1, t + 4, 8'h00, 3'(k % 8));
      p8(t + 5, t + 19, ch8[k % 8], 3'(k % 8), (k == 8) ? t + 5 : -1);
      at(t + 1); cr8 = 1'b0;
    end
    for (int k = 1; k <= 5; k++) begin
      t = 170 + 20 * k;
      at(t); cr8 = 1'b1;
      p8(t + 1, t + 4, 8'h00, 3'(k));
      p8(t + 5, t + 19, ch8[k], 3'(k));
      at(t + 1); cr8 = 1'b0;
    end
    // Channel 5: sync edge together with column_ready.
    at(290); cr8 = 1'b1; sync8 = 1'b1;
    p8(291, 294, 8'h00, 3'd0);
    p8(295, 310, 8'h01, 3'd0);
    at(291); cr8 = 1'b0;
    at(300); sync8 = 1'b0;
    // Second column_ready inside the gap.
    at(310); cr8 = 1'b1;
    p8(311, 314, 8'h00, 3'd1, -1, 313);
    p8(315, 330, 8'h02, 3'd1);
    at(311); cr8 = 1'b0;
    at(312); cr8 = 1'b1;
    at(313); cr8 = 1'b0;
    // Manual pass-through, then back to auto.
    at(330); mode8 = 1'b0; sel8 = 8'hA5;
    p8(331, 340, 8'hA5, 3'd0);
    at(340); mode8 = 1'b1;
    p8(341, 350, 8'h00, 3'd0);
    at(350); cr8 = 1'b1;
    p8(351, 354, 8'h00, 3'd0);
    p8(355, 360, 8'h01, 3'd0);
    at(351); cr8 = 1'b0;
    at(360); cr8 = 1'b1;
    p8(361, 364, 8'h00, 3'd1);
    p8(365, 370, 8'h02, 3'd1);
    at(361); cr8 = 1'b0;
    // Enable low overrides the running sequence.
    at(370); en8 = 1'b0;
    p8(371, 380, 8'h00, 3'd0);
    at(375); en8 = 1'b1;
    at(381);
  endtask

  task automatic run5();
    int t;
    p5(1, 9, 5'h1F, 3'd0);
    at(3); nrst5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      t = 10 + 5 * k;
      at(t); cr5 = 1'b1;
      p5(t + 1, (k == 5) ? 39 : t + 5, val5[k], ix5[k], (k == 5) ? t + 1 : -1);
      at(t + 1); cr5 = 1'b0;
    end
    // Reset mid-run: pins go all-off immediately, stay idle after release.
    at(40); nrst5 = 1'b0;
    p5(40, 50, 5'h1F, 3'd0);
    at(43); nrst5 = 1'b1;
    at(50); cr5 = 1'b1;
    p5(51, 55, 5'h1E, 3'd0);
    at(51); cr5 = 1'b0;
    at(56);
  endtask

  initial begin
    nrst8 = 1'b0; en8 = 1'b1; mode8 = 1'b1; sel8 = 8'h00; cr8 = 1'b0; sync8 = 1'b0;
    nrst5 = 1'b0; en5 = 1'b1; mode5 = 1'b1; sel5 = 5'h00; cr5 = 1'b0; sync5 = 1'b0;
    fork
      run8();
      run5();
    join
    stim_done = 1'b1;
  end

  initial begin
    forever begin
      @(negedge clk);
      while (q8.size() > 0 && q8[0].cyc <= cyc) begin
        e = q8.pop_front();
        total++;
        if (e.cyc != cyc || out8 !== e.out || idx8 !== e.idx || td8 !== e.turn
            || ov8 !== e.over) begin
          bad++;
          $display("FAIL dut8 cyc=%0d(exp for %0d): got out=%h idx=%0d turn=%b over=%b, want out=%h idx=%0d turn=%b over=%b",
                   cyc, e.cyc, out8, idx8, td8, ov8, e.out, e.idx, e.turn, e.over);
        end
      end
      while (q5.size() > 0 && q5[0].cyc <= cyc) begin
        e = q5.pop_front();
        total++;
        if (e.cyc != cyc || {3'b000, out5} !== e.out || idx5 !== e.idx || td5 !== e.turn
            || ov5 !== e.over) begin
          bad++;
          $display("FAIL dut5 cyc=%0d(exp for %0d): got out=%h idx=%0d turn=%b over=%b, want out=%h idx=%0d turn=%b over=%b",
                   cyc, e.cyc, out5, idx5, td5, ov5, e.out[4:0], e.idx, e.turn, e.over);
        end
      end
      if (stim_done) begin
        drain++;
        if (drain == 3) begin
          if (q8.size() + q5.size() > 0) begin
            total += q8.size() + q5.size();
            bad += q8.size() + q5.size();
            $display("FAIL leftover expectations: got %0d unchecked, want 0", q8.size() + q5.size());
          end
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cyc=%0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
